// File: rtl/fust_issue_s_if.sv
// rtl/fust_issue_s_if.sv - issue port between the FUST issue stage and the scalar FUs
interface fust_issue_s_if #(
    parameter int NUM_FU = 4,
    parameter int OP_W   = 32,
    parameter int FU_W   = $clog2(NUM_FU)
);
    logic              issue_valid;
    logic [FU_W-1:0]   issue_fu;
    logic [OP_W-1:0]   issue_row;
    logic [NUM_FU-1:0] fu_ready;

    modport master (
        output issue_valid, issue_fu, issue_row,
        input  fu_ready
    );

    modport slave (
        input  issue_valid, issue_fu, issue_row,
        output fu_ready
    );
endinterface

// File: rtl/fust_issue_s.sv
// rtl/fust_issue_s.sv - round-robin issue from the scalar FUST into a registered FU port
module fust_issue_s #(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = 3,
    parameter int OP_W   = 32,
    parameter int FU_W   = $clog2(NUM_FU)
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [NUM_FU-1:0]        fust_busy,
    input  logic [NUM_FU*TAG_W-1:0]  fust_t1,
    input  logic [NUM_FU*TAG_W-1:0]  fust_t2,
    input  logic [NUM_FU*OP_W-1:0]   fust_op,
    input  logic                     wb_valid,
    input  logic [TAG_W-1:0]         wb_tag,
    fust_issue_s_if.master           iss,
    output logic                     fust_clr_en,
    output logic [FU_W-1:0]          fust_clr_fu
);
    logic              issue_valid_q, issue_valid_d;
    logic [FU_W-1:0]   issue_fu_q, issue_fu_d;
    logic [OP_W-1:0]   issue_row_q, issue_row_d;
    logic              clr_en_q, clr_en_d;
    logic [FU_W-1:0]   clr_fu_q, clr_fu_d;
    logic [FU_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_FU-1:0] issued_q, issued_d;

    logic [NUM_FU-1:0] eligible;
    logic [TAG_W-1:0]  t1, t2;
    logic              found;
    logic [FU_W-1:0]   sel;
    logic              transfer;
    logic              load;
    int                idx;

    assign transfer = issue_valid_q && iss.fu_ready[issue_fu_q];
    assign load     = found && (!issue_valid_q || iss.fu_ready[issue_fu_q]);

    // Wakeup bypass: a same-cycle writeback of a source tag counts as ready.
    always_comb begin
        eligible = '0;
        t1       = '0;
        t2       = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            t1 = fust_t1[i*TAG_W +: TAG_W];
            t2 = fust_t2[i*TAG_W +: TAG_W];
            eligible[i] = fust_busy[i] && !issued_q[i]
                       && ((t1 == '0) || (wb_valid && (t1 == wb_tag)))
                       && ((t2 == '0) || (wb_valid && (t2 == wb_tag)));
        end
    end

    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_FU;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                sel   = FU_W'(idx);
            end
        end
    end

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_fu_d    = issue_fu_q;
        issue_row_d   = issue_row_q;
        clr_en_d      = 1'b0;
        clr_fu_d      = clr_fu_q;
        rr_ptr_d      = rr_ptr_q;
        // Hold issued rows until the FUST busy bit actually falls.
        issued_d      = issued_q & fust_busy;
        if (load) begin
            issue_valid_d = 1'b1;
            issue_fu_d    = sel;
            issue_row_d   = fust_op[int'(sel)*OP_W +: OP_W];
            clr_en_d      = 1'b1;
            clr_fu_d      = sel;
            rr_ptr_d      = (sel == FU_W'(NUM_FU - 1)) ? '0 : sel + FU_W'(1);
            issued_d[sel] = 1'b1;
        end else if (transfer) begin
            issue_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            issue_valid_q <= 1'b0;
            issue_fu_q    <= '0;
            issue_row_q   <= '0;
            clr_en_q      <= 1'b0;
            clr_fu_q      <= '0;
            rr_ptr_q      <= '0;
            issued_q      <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_fu_q    <= issue_fu_d;
            issue_row_q   <= issue_row_d;
            clr_en_q      <= clr_en_d;
            clr_fu_q      <= clr_fu_d;
            rr_ptr_q      <= rr_ptr_d;
            issued_q      <= issued_d;
        end
    end

    assign iss.issue_valid = issue_valid_q;
    assign iss.issue_fu    = issue_fu_q;
    assign iss.issue_row   = issue_row_q;
    assign fust_clr_en     = clr_en_q;
    assign fust_clr_fu     = clr_fu_q;
endmodule

// File: tb/tb_fust_issue_s.sv
// tb/tb_fust_issue_s.sv - directed self-checking bench for fust_issue_s
module tb_fust_issue_s;
    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    logic [3:0]   busy4;
    logic [11:0]  t1_4, t2_4;
    logic [127:0] op4;
    logic         wb_valid;
    logic [2:0]   wb_tag;
    logic         clr_en4;
    logic [1:0]   clr_fu4;

    logic [7:0]   busy8;
    logic [23:0]  t1_8, t2_8;
    logic [255:0] op8;
    logic         clr_en8;
    logic [2:0]   clr_fu8;

    fust_issue_s_if #(.NUM_FU(4), .OP_W(32)) if4 ();
    fust_issue_s_if #(.NUM_FU(8), .OP_W(32)) if8 ();

    fust_issue_s #(.NUM_FU(4), .TAG_W(3), .OP_W(32)) dut4 (
        .CLK(CLK), .nRST(nRST), .fust_busy(busy4), .fust_t1(t1_4), .fust_t2(t2_4),
        .fust_op(op4), .wb_valid(wb_valid), .wb_tag(wb_tag), .iss(if4),
        .fust_clr_en(clr_en4), .fust_clr_fu(clr_fu4)
    );

    fust_issue_s #(.NUM_FU(8), .TAG_W(3), .OP_W(32)) dut8 (
        .CLK(CLK), .nRST(nRST), .fust_busy(busy8), .fust_t1(t1_8), .fust_t2(t2_8),
        .fust_op(op8), .wb_valid(wb_valid), .wb_tag(wb_tag), .iss(if8),
        .fust_clr_en(clr_en8), .fust_clr_fu(clr_fu8)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect4(input string tag, input logic v, input logic [1:0] fu,
                           input logic ce, input logic [1:0] cf);
        check({tag, ".valid"}, 64'(if4.issue_valid), 64'(v));
        check({tag, ".clr_en"}, 64'(clr_en4), 64'(ce));
        if (v) begin
            check({tag, ".fu"}, 64'(if4.issue_fu), 64'(fu));
            check({tag, ".row"}, 64'(if4.issue_row), 64'(op4[fu*32 +: 32]));
        end
        if (ce) check({tag, ".clr_fu"}, 64'(clr_fu4), 64'(cf));
    endtask

    initial begin
        nRST = 1'b0;
        busy4 = '0; t1_4 = '0; t2_4 = '0;
        op4 = {32'hC3C3_0003, 32'hDEAD_BEEF, 32'hB1B1_0001, 32'hA0A0_0000};
        busy8 = '0; t1_8 = '0; t2_8 = '0;
        for (int i = 0; i < 8; i++) op8[i*32 +: 32] = 32'h8000_0000 + 32'(i);
        wb_valid = 1'b0; wb_tag = '0;
        if4.fu_ready = '0; if8.fu_ready = '0;
        tick(); tick();
        check("rst.valid", 64'(if4.issue_valid), 64'd0);
        check("rst.clr_en", 64'(clr_en4), 64'd0);
        check("rst.row", 64'(if4.issue_row), 64'd0);
        nRST = 1'b1;

        // single issue, no reissue while busy stays high
        busy4 = 4'b0100; if4.fu_ready = 4'b0100;
        tick(); expect4("t1.issue", 1'b1, 2'd2, 1'b1, 2'd2);
        tick(); expect4("t1.drain", 1'b0, 2'd0, 1'b0, 2'd0);
        tick(); expect4("t1.hold", 1'b0, 2'd0, 1'b0, 2'd0);
        busy4 = 4'b0000;
        tick();

        nRST = 1'b0; tick(); nRST = 1'b1;

        // round robin 0,1,3 then 0,3
        busy4 = 4'b1011; if4.fu_ready = 4'b1111;
        tick(); expect4("t2.a", 1'b1, 2'd0, 1'b1, 2'd0);
        tick(); expect4("t2.b", 1'b1, 2'd1, 1'b1, 2'd1);
        tick(); expect4("t2.c", 1'b1, 2'd3, 1'b1, 2'd3);
        busy4 = 4'b0000;
        tick(); expect4("t2.idle", 1'b0, 2'd0, 1'b0, 2'd0);
        busy4 = 4'b1001;
        tick(); expect4("t2.d", 1'b1, 2'd0, 1'b1, 2'd0);
        tick(); expect4("t2.e", 1'b1, 2'd3, 1'b1, 2'd3);
        busy4 = 4'b0000;
        tick(); expect4("t2.idle2", 1'b0, 2'd0, 1'b0, 2'd0);

        // wakeup bypass on row 1 source-1 tag 5
        busy4 = 4'b0010; t1_4 = 12'b000_000_101_000;
        tick(); expect4("t3.wait", 1'b0, 2'd0, 1'b0, 2'd0);
        wb_valid = 1'b1; wb_tag = 3'd5;
        tick(); expect4("t3.wake", 1'b1, 2'd1, 1'b1, 2'd1);
        wb_valid = 1'b0;
        tick(); expect4("t3.drain", 1'b0, 2'd0, 1'b0, 2'd0);
        busy4 = 4'b0000;
        tick();
        busy4 = 4'b0010; wb_valid = 1'b1; wb_tag = 3'd6;
        tick(); expect4("t3.wrongtag", 1'b0, 2'd0, 1'b0, 2'd0);
        wb_valid = 1'b0;
        tick(); expect4("t3.still", 1'b0, 2'd0, 1'b0, 2'd0);
        busy4 = 4'b0000; t1_4 = '0;
        tick();

        // stall on fu_ready[0], then back-to-back row 1
        busy4 = 4'b0001; if4.fu_ready = 4'b1110;
        tick(); expect4("t4.issue", 1'b1, 2'd0, 1'b1, 2'd0);
        busy4 = 4'b0011;
        for (int s = 0; s < 3; s++) begin
            tick(); expect4("t4.stall", 1'b1, 2'd0, 1'b0, 2'd0);
        end
        if4.fu_ready = 4'b1111;
        tick(); expect4("t4.b2b", 1'b1, 2'd1, 1'b1, 2'd1);
        busy4 = 4'b0000;
        tick(); expect4("t4.drain", 1'b0, 2'd0, 1'b0, 2'd0);

        // asynchronous reset with an op held
        busy4 = 4'b1100; if4.fu_ready = 4'b0000;
        tick(); expect4("t5.held", 1'b1, 2'd2, 1'b1, 2'd2);
        #3 nRST = 1'b0;
        #1;
        check("t5.rst.valid", 64'(if4.issue_valid), 64'd0);
        check("t5.rst.clr_en", 64'(clr_en4), 64'd0);
        check("t5.rst.fu", 64'(if4.issue_fu), 64'd0);
        busy4 = 4'b1111; if4.fu_ready = 4'b1111;
        #2 nRST = 1'b1;
        tick(); expect4("t5.r0", 1'b1, 2'd0, 1'b1, 2'd0);
        tick(); expect4("t5.r1", 1'b1, 2'd1, 1'b1, 2'd1);
        tick(); expect4("t5.r2", 1'b1, 2'd2, 1'b1, 2'd2);
        tick(); expect4("t5.r3", 1'b1, 2'd3, 1'b1, 2'd3);
        busy4 = 4'b0000;
        tick();

        // NUM_FU=8 wrap-around from rr_ptr=6
        busy8 = 8'h20; if8.fu_ready = 8'hFF;
        tick();
        check("t6.fu5", 64'(if8.issue_fu), 64'd5);
        check("t6.clr5", 64'(clr_fu8), 64'd5);
        busy8 = 8'hDF;
        tick();
        check("t6.fu6", 64'(if8.issue_fu), 64'd6);
        check("t6.row6", 64'(if8.issue_row), 64'h8000_0006);
        tick(); check("t6.fu7", 64'(if8.issue_fu), 64'd7);
        tick();
        check("t6.fu0", 64'(if8.issue_fu), 64'd0);
        check("t6.row0", 64'(if8.issue_row), 64'h8000_0000);
        check("t6.clr_en0", 64'(clr_en8), 64'd1);
        tick(); check("t6.fu1", 64'(if8.issue_fu), 64'd1);
        check("t6.valid", 64'(if8.issue_valid), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fust_issue_s.md
Name: fust_issue_s

Overview:
- Read/issue side of the scalar functional-unit status table (FUST).
- Each cycle, scans the FUST rows (one row per scalar FU) and picks one row that is busy with both source tags resolved. Forwards that row's op to its FU through a registered valid/ready port.
- Returns a one-cycle clear request so the FUST writer retires the row.
- Sits between the scalar FUST and the scalar FU pipelines.

Parameters:
- NUM_FU, 4, number of scalar FUs / FUST rows; row index equals FU index.
- TAG_W, 3, source-tag width; tag value 0 means the operand is ready.
- OP_W, 32, width of one FUST op row.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- nRST  input  1  reset, asynchronous, active-low.
- fust_busy  input  NUM_FU  per-row busy bits from the FUST.
- fust_t1  input  NUM_FU*TAG_W  per-row source-1 tags; row i occupies bits [i*TAG_W +: TAG_W].
- fust_t2  input  NUM_FU*TAG_W  per-row source-2 tags, same packing as fust_t1.
- fust_op  input  NUM_FU*OP_W  per-row op contents, packed the same way.
- wb_valid  input  1  writeback tag broadcast valid.
- wb_tag  input  TAG_W  tag being written back.
- fu_ready  input  NUM_FU  per-FU accept signal.
- issue_valid  output  1  issue register holds a valid op.
- issue_fu  output  $clog2(NUM_FU)  destination FU / source row of the held op.
- issue_row  output  OP_W  held op contents.
- fust_clr_en  output  1  one-cycle pulse requesting that the FUST clear the busy bit of row fust_clr_fu.
- fust_clr_fu  output  $clog2(NUM_FU)  row to clear.

Behaviour:
- Reset (nRST low, asynchronous): the following all go to 0 and hold there while nRST is low:
  - issue_valid, issue_fu, issue_row;
  - fust_clr_en, fust_clr_fu;
  - rr_ptr;
  - the issued mask.
- Reset mid-handshake drops the held op; the FUST writer is responsible for its own reset.
- Operand ready, per source: tag == 0, OR (wb_valid && tag == wb_tag). The second term is a same-cycle wakeup bypass; a broadcast of tag 0 has no extra effect.
- Internal issued[NUM_FU] mask:
  - issued[i] is set when row i is loaded into the issue register.
  - issued[i] clears on any edge where fust_busy[i] == 0.
  - This covers the lag between fust_clr_en and the FUST busy bit falling.
- Eligible[i] = fust_busy[i] & ~issued[i] & t1 ready & t2 ready.
- Selection is round-robin over eligible rows, starting at rr_ptr and searching upward with wrap-around; the first eligible row wins.
- load = any eligible && (~issue_valid || fu_ready[issue_fu]).
- On load, at the next edge:
  - issue_valid = 1, issue_fu = sel, issue_row = fust_op row sel;
  - issued[sel] = 1;
  - rr_ptr = (sel+1) mod NUM_FU;
  - fust_clr_en = 1, fust_clr_fu = sel.
- Otherwise fust_clr_en = 0. It is therefore high for exactly one cycle per issue.
- Handshake:
  - Transfer occurs on any edge with issue_valid && fu_ready[issue_fu].
  - issue_fu and issue_row are stable while issue_valid is high and no transfer has occurred.
  - fu_ready of other FUs is ignored.
- Transfer with no new load: issue_valid goes to 0.
- Transfer with a load on the same edge: back-to-back issue, so issue_valid stays 1 with the new contents. Sustained throughput is 1 op/cycle.
- Latency: row eligible at edge N → issue_valid at edge N+1 (if the register is free or draining).
- rr_ptr advances only on load; it is unchanged while stalled.
- No eligible row: the register simply drains, and no clear is issued.
- A row whose busy bit falls while it is eligible (FUST overwrite) is not selected that cycle, because eligibility is combinational from fust_busy.
- A row re-written busy on the same edge its issued bit clears becomes eligible on the following cycle.

Test Plan:
1. Reset, then row 2 busy with t1=0, t2=0, op=0xDEADBEEF, fu_ready=4'b0100 → next cycle issue_valid=1, issue_fu=2, issue_row=0xDEADBEEF, fust_clr_en=1, fust_clr_fu=2. One cycle later issue_valid=0 and fust_clr_en=0; row 2 is not reissued while fust_busy[2] stays high for 2 more cycles.
2. Rows 0,1,3 all ready, fu_ready all 1 → issue order 0,1,3 on consecutive cycles, then rr_ptr=0. Reload rows 0 and 3 → order 0,3.
3. Row 1 with t1=5, t2=0 is held; assert wb_valid=1, wb_tag=5 for one cycle → issue_fu=1 valid the next cycle. Same with wb_tag=6 → no issue.
4. Row 0 issued with fu_ready[0]=0 for 3 cycles while row 1 is ready → issue_fu=0, issue_row stay constant; row 1 not loaded. Raise fu_ready[0] → row 1 appears the next cycle (back-to-back), fust_clr_fu=1.
5. Assert nRST=0 asynchronously mid-cycle with issue_valid=1 → issue_valid, fust_clr_en, and the issued mask go to 0 immediately. After release with rows still busy, rows reissue starting from row 0.
6. NUM_FU=8, all rows ready, rr_ptr=6 → selection order 6,7,0,1,…; check wrap-around and the 3-bit issue_fu.
